// File: rtl/ehl_ahb_matrix_out_pkg.sv
// ehl_ahb_matrix_out_pkg: AHB encodings and the address-phase record shared by the output stage
package ehl_ahb_matrix_out_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
    localparam logic [1:0] HRESP_OKAY    = 2'd0;
    localparam logic [1:0] HRESP_ERROR   = 2'd1;

    typedef struct packed {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
    } ahb_addr_t;

    function automatic logic is_xfer(input logic [1:0] t);
        return t == HTRANS_NONSEQ || t == HTRANS_SEQ;
    endfunction
endpackage

// File: rtl/ehl_ahb_matrix_out_if.sv
// ehl_ahb_matrix_out_if: master-facing and slave-facing buses of one matrix output stage
interface ehl_ahb_matrix_out_if #(
    parameter int MNUM = 2
);
    logic [MNUM*2-1:0]  im_htrans;
    logic [MNUM*32-1:0] im_haddr;
    logic [MNUM-1:0]    im_hwrite;
    logic [MNUM*3-1:0]  im_hsize;
    logic [MNUM*3-1:0]  im_hburst;
    logic [MNUM*32-1:0] im_hwdata;
    logic [MNUM-1:0]    im_hready;
    logic [MNUM-1:0]    om_hready;
    logic [MNUM*2-1:0]  om_hresp;
    logic [31:0]        om_hrdata;
    logic               os_hsel;
    logic [31:0]        os_haddr;
    logic [1:0]         os_htrans;
    logic               os_hwrite;
    logic [2:0]         os_hsize;
    logic [2:0]         os_hburst;
    logic [31:0]        os_hwdata;
    logic               os_hreadyin;
    logic [31:0]        is_hrdata;
    logic               is_hready;
    logic [1:0]         is_hresp;

    // slave: the output stage itself; master: the input stages and slave around it
    modport slave (
        input  im_htrans, im_haddr, im_hwrite, im_hsize, im_hburst, im_hwdata, im_hready,
        input  is_hrdata, is_hready, is_hresp,
        output om_hready, om_hresp, om_hrdata,
        output os_hsel, os_haddr, os_htrans, os_hwrite, os_hsize, os_hburst, os_hwdata, os_hreadyin
    );
    modport master (
        output im_htrans, im_haddr, im_hwrite, im_hsize, im_hburst, im_hwdata, im_hready,
        output is_hrdata, is_hready, is_hresp,
        input  om_hready, om_hresp, om_hrdata,
        input  os_hsel, os_haddr, os_htrans, os_hwrite, os_hsize, os_hburst, os_hwdata, os_hreadyin
    );
endinterface

// File: rtl/ehl_rr_arbiter.sv
// ehl_rr_arbiter: one-hot grant over a request vector, round-robin from an internal pointer
// Build option EHL_AHB_MATRIX_OUT_FIXED_PRIO_EN: fixed priority (lowest index wins), no pointer
module ehl_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         hclk,
    input  logic         hresetn,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
`ifdef EHL_AHB_MATRIX_OUT_FIXED_PRIO_EN
    logic unused;
    assign unused = ^{hclk, hresetn, en};
    assign gnt = req & (~req + 1'b1);
`else
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr;
    logic [N-1:0]  rot;
    int            gi;
    // search begins at the pointer; the first request met after rotation wins
    always_comb begin
        rot = N'({req, req} >> ptr);
        gi = 0;
        for (int k = N - 1; k >= 0; k--) if (rot[k]) gi = int'(ptr) + k;
        if (gi >= N) gi = gi - N;
        gnt = '0;
        for (int k = 0; k < N; k++) gnt[k] = |req && gi == k;
    end
    // pointer moves just past the master granted while arbitration is enabled
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) ptr <= '0;
        else if (en && |req) ptr <= PW'(gi == N - 1 ? 0 : gi + 1);
`endif
endmodule

// File: rtl/ehl_ahb_matrix_out.sv
// ehl_ahb_matrix_out: slave-side output stage of the AHB matrix, one instance per slave port
// Arbitrates the masters addressing this slave, parks losing requests in holding registers
// and routes the data phase back to its owner.
// Build option EHL_AHB_MATRIX_OUT_FIXED_PRIO_EN: fixed-priority arbitration instead of round-robin.
module ehl_ahb_matrix_out
    import ehl_ahb_matrix_out_pkg::*;
#(
    parameter int MNUM = 2
) (
    input logic                 hclk,
    input logic                 hresetn,
    ehl_ahb_matrix_out_if.slave bus
);
    localparam int AW = MNUM > 1 ? $clog2(MNUM) : 1;

    ahb_addr_t         live [MNUM];
    ahb_addr_t         eff  [MNUM];
    ahb_addr_t         pend [MNUM];
    ahb_addr_t         fwd;
    logic [MNUM-1:0]   pend_v, pres, req, cap, gnt, is_dat, hready;
    logic [2*MNUM-1:0] hresp;
    logic [AW-1:0]     a_own, own, arb_idx, d_own;
    logic              d_v, run, lock, arb_en;
    logic [31:0]       hwdata;

    // per-master view: live bus, presented transfer, request and the fields it would forward
    always_comb begin
        for (int m = 0; m < MNUM; m++) begin
            live[m] = {bus.im_htrans[2*m+:2], bus.im_haddr[32*m+:32], bus.im_hwrite[m],
                       bus.im_hsize[3*m+:3], bus.im_hburst[3*m+:3]};
            is_dat[m] = d_v && d_own == AW'(m);
            pres[m] = run && bus.im_hready[m] && is_xfer(live[m].trans);
            req[m] = pend_v[m] || pres[m];
            eff[m] = pend_v[m] ? pend[m] : (run && (bus.im_hready[m] || is_dat[m])) ? live[m] : '0;
        end
    end

    assign lock   = eff[a_own].trans == HTRANS_SEQ || eff[a_own].trans == HTRANS_BUSY;
    assign arb_en = bus.is_hready && !lock;

    ehl_rr_arbiter #(.N(MNUM)) u_arb (
        .hclk    (hclk),
        .hresetn (hresetn),
        .req     (req),
        .en      (arb_en),
        .gnt     (gnt)
    );

    // address owner, forwarded fields, capture of losers and per-master responses
    always_comb begin
        arb_idx = a_own;
        for (int m = 0; m < MNUM; m++) if (gnt[m]) arb_idx = AW'(m);
        own = bus.is_hready && !lock && |req ? arb_idx : a_own;
        fwd = eff[own].trans == HTRANS_IDLE ? '0 : eff[own];
        hwdata = '0;
        for (int m = 0; m < MNUM; m++) begin
            cap[m] = pres[m] && !pend_v[m] && !(bus.is_hready && own == AW'(m));
            hready[m] = is_dat[m] ? bus.is_hready : !(pend_v[m] || cap[m]);
            hresp[2*m+:2] = is_dat[m] ? bus.is_hresp : HRESP_OKAY;
            if (is_dat[m]) hwdata = bus.im_hwdata[32*m+:32];
        end
    end

    assign bus.os_htrans   = fwd.trans;
    assign bus.os_hsel     = fwd.trans != HTRANS_IDLE;
    assign bus.os_haddr    = fwd.addr;
    assign bus.os_hwrite   = fwd.write;
    assign bus.os_hsize    = fwd.size;
    assign bus.os_hburst   = fwd.burst;
    assign bus.os_hwdata   = hwdata;
    assign bus.os_hreadyin = bus.is_hready;
    assign bus.om_hready   = hready;
    assign bus.om_hresp    = hresp;
    assign bus.om_hrdata   = bus.is_hrdata;

    // run gates the master inputs so reset forces idle outputs at once; owners advance on hready
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) begin
            run   <= 1'b0;
            a_own <= '0;
            d_v   <= 1'b0;
            d_own <= '0;
        end else begin
            run   <= 1'b1;
            a_own <= own;
            if (bus.is_hready) begin
                d_v   <= is_xfer(fwd.trans);
                d_own <= own;
            end
        end

    // holding registers: load a transfer that was not forwarded, drop it once forwarded
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) begin
            pend_v <= '0;
            for (int m = 0; m < MNUM; m++) pend[m] <= '0;
        end else begin
            for (int m = 0; m < MNUM; m++)
                if (cap[m]) begin
                    pend_v[m] <= 1'b1;
                    pend[m]   <= live[m];
                end else if (pend_v[m] && bus.is_hready && own == AW'(m)) pend_v[m] <= 1'b0;
        end
endmodule

// File: tb/tb_ehl_ahb_matrix_out.sv
// tb_ehl_ahb_matrix_out: directed bench for the matrix output stage with three masters
module tb_ehl_ahb_matrix_out;
    import ehl_ahb_matrix_out_pkg::*;
    localparam int MNUM = 3;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ehl_ahb_matrix_out_if #(.MNUM(MNUM)) bus ();
    ehl_ahb_matrix_out #(.MNUM(MNUM)) dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input int m, input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] b);
        bus.im_htrans[2*m+:2]  = t;
        bus.im_haddr[32*m+:32] = a;
        bus.im_hwrite[m]       = w;
        bus.im_hsize[3*m+:3]   = 3'd2;
        bus.im_hburst[3*m+:3]  = b;
    endtask

    task automatic idle_all();
        bus.im_htrans = '0;
        bus.im_haddr  = '0;
        bus.im_hwrite = '0;
        bus.im_hsize  = '0;
        bus.im_hburst = '0;
        bus.im_hwdata = '0;
        bus.im_hready = '1;
        bus.is_hrdata = '0;
        bus.is_hready = 1'b1;
        bus.is_hresp  = HRESP_OKAY;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        idle_all();
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        idle_all();
        drive(0, HTRANS_NONSEQ, 32'h10, 1'b0, 3'd0);
        drive(1, HTRANS_NONSEQ, 32'h20, 1'b0, 3'd0);
        repeat (2) @(posedge hclk);
        #1;
        checks++;
        if (bus.om_hready !== 3'b111) begin errors++; $display("FAIL reset_hready: got %b expected 111", bus.om_hready); end
        checks++;
        if ({bus.os_hsel, bus.os_htrans, bus.os_haddr} !== 35'd0) begin errors++; $display("FAIL reset_os: got sel=%b trans=%0d addr=%h expected 0/0/0", bus.os_hsel, bus.os_htrans, bus.os_haddr); end
        checks++;
        if (bus.om_hresp !== 6'd0) begin errors++; $display("FAIL reset_hresp: got %b expected 000000", bus.om_hresp); end
        do_reset();
        checks++;
        if ({bus.os_hsel, bus.os_htrans} !== 3'd0) begin errors++; $display("FAIL reset_idle: got sel=%b trans=%0d expected 0/0", bus.os_hsel, bus.os_htrans); end
    endtask

    task automatic test_single();
        do_reset();
        drive(0, HTRANS_NONSEQ, 32'h0000_1000, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_hsel, bus.os_htrans, bus.os_haddr, bus.os_hwrite} !== {1'b1, 2'd2, 32'h1000, 1'b0}) begin errors++; $display("FAIL single_addr: got sel=%b trans=%0d addr=%h wr=%b expected 1/2/00001000/0", bus.os_hsel, bus.os_htrans, bus.os_haddr, bus.os_hwrite); end
        tick();
        drive(0, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        bus.is_hrdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({bus.om_hrdata, bus.om_hready[0]} !== {32'hCAFE_F00D, 1'b1}) begin errors++; $display("FAIL single_rdata: got rdata=%h hready0=%b expected cafef00d/1", bus.om_hrdata, bus.om_hready[0]); end
        checks++;
        if ({bus.os_hsel, bus.os_htrans} !== 3'd0) begin errors++; $display("FAIL single_idle: got sel=%b trans=%0d expected 0/0", bus.os_hsel, bus.os_htrans); end
        tick();
        drive(0, HTRANS_NONSEQ, 32'h0000_2000, 1'b1, 3'd0);
        tick();
        drive(0, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        bus.im_hwdata[31:0] = 32'h1234_5678;
        #1;
        checks++;
        if (bus.os_hwdata !== 32'h1234_5678) begin errors++; $display("FAIL single_wdata: got %h expected 12345678", bus.os_hwdata); end
    endtask

    task automatic test_contention();
        do_reset();
        drive(0, HTRANS_NONSEQ, 32'h100, 1'b0, 3'd0);
        drive(1, HTRANS_NONSEQ, 32'h200, 1'b1, 3'd0);
        #1;
        checks++;
        if ({bus.os_htrans, bus.os_haddr} !== {2'd2, 32'h100}) begin errors++; $display("FAIL cont_first: got trans=%0d addr=%h expected 2/00000100", bus.os_htrans, bus.os_haddr); end
        checks++;
        if (bus.om_hready !== 3'b101) begin errors++; $display("FAIL cont_stall: got %b expected 101", bus.om_hready); end
        tick();
        bus.im_hready = 3'b101;
        drive(0, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        drive(1, HTRANS_NONSEQ, 32'h0BAD, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_htrans, bus.os_haddr, bus.os_hwrite} !== {2'd2, 32'h200, 1'b1}) begin errors++; $display("FAIL cont_pending: got trans=%0d addr=%h wr=%b expected 2/00000200/1", bus.os_htrans, bus.os_haddr, bus.os_hwrite); end
        checks++;
        if (bus.om_hready !== 3'b101) begin errors++; $display("FAIL cont_hold: got %b expected 101", bus.om_hready); end
        tick();
        bus.im_hready = 3'b111;
        drive(1, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        bus.im_hwdata[63:32] = 32'hA5A5_0001;
        #1;
        checks++;
        if ({bus.om_hready, bus.os_hwdata} !== {3'b111, 32'hA5A5_0001}) begin errors++; $display("FAIL cont_release: got hready=%b wdata=%h expected 111/a5a50001", bus.om_hready, bus.os_hwdata); end
    endtask

    task automatic test_burst_lock();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        for (int b = 0; b < 4; b++) begin
            drive(0, b == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, exp_addr[b], 1'b0, 3'd3);
            if (b == 2) drive(1, HTRANS_NONSEQ, 32'h100, 1'b0, 3'd0);
            bus.im_hready = b == 3 ? 3'b101 : 3'b111;
            #1;
            checks++;
            if ({bus.os_htrans, bus.os_haddr, bus.os_hburst} !== {b == 0 ? 2'd2 : 2'd3, exp_addr[b], 3'd3}) begin errors++; $display("FAIL burst_beat%0d: got trans=%0d addr=%h burst=%0d expected addr %h", b, bus.os_htrans, bus.os_haddr, bus.os_hburst, exp_addr[b]); end
            if (b >= 2) begin
                checks++;
                if (bus.om_hready[1] !== 1'b0) begin errors++; $display("FAIL burst_stall%0d: got hready1=%b expected 0", b, bus.om_hready[1]); end
            end
            tick();
        end
        drive(0, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_htrans, bus.os_haddr, bus.om_hready[1]} !== {2'd2, 32'h100, 1'b0}) begin errors++; $display("FAIL burst_next: got trans=%0d addr=%h hready1=%b expected 2/00000100/0", bus.os_htrans, bus.os_haddr, bus.om_hready[1]); end
        tick();
        bus.im_hready = 3'b111;
        drive(1, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        #1;
        checks++;
        if (bus.om_hready !== 3'b111) begin errors++; $display("FAIL burst_done: got %b expected 111", bus.om_hready); end
    endtask

    task automatic test_wait();
        do_reset();
        drive(0, HTRANS_NONSEQ, 32'h300, 1'b0, 3'd0);
        tick();
        bus.is_hready = 1'b0;
        bus.im_hready = 3'b110;
        drive(0, HTRANS_NONSEQ, 32'h304, 1'b0, 3'd0);
        drive(1, HTRANS_NONSEQ, 32'h400, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_htrans, bus.os_haddr, bus.om_hready} !== {2'd2, 32'h304, 3'b100}) begin errors++; $display("FAIL wait_c1: got trans=%0d addr=%h hready=%b expected 2/00000304/100", bus.os_htrans, bus.os_haddr, bus.om_hready); end
        tick();
        bus.im_hready = 3'b100;
        #1;
        checks++;
        if ({bus.os_htrans, bus.os_haddr, bus.om_hready, bus.os_hreadyin} !== {2'd2, 32'h304, 3'b100, 1'b0}) begin errors++; $display("FAIL wait_c2: got trans=%0d addr=%h hready=%b readyin=%b expected 2/00000304/100/0", bus.os_htrans, bus.os_haddr, bus.om_hready, bus.os_hreadyin); end
        tick();
        bus.is_hready = 1'b1;
        bus.im_hready = 3'b101;
        #1;
        checks++;
        if ({bus.os_haddr, bus.om_hready} !== {32'h400, 3'b101}) begin errors++; $display("FAIL wait_end: got addr=%h hready=%b expected 00000400/101", bus.os_haddr, bus.om_hready); end
        tick();
        bus.im_hready = 3'b110;
        drive(0, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        drive(1, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_haddr, bus.om_hready} !== {32'h304, 3'b110}) begin errors++; $display("FAIL wait_pend0: got addr=%h hready=%b expected 00000304/110", bus.os_haddr, bus.om_hready); end
    endtask

    task automatic test_error();
        do_reset();
        drive(1, HTRANS_NONSEQ, 32'h500, 1'b1, 3'd0);
        #1;
        checks++;
        if ({bus.os_htrans, bus.os_haddr} !== {2'd2, 32'h500}) begin errors++; $display("FAIL err_addr: got trans=%0d addr=%h expected 2/00000500", bus.os_htrans, bus.os_haddr); end
        tick();
        drive(1, HTRANS_IDLE, 32'h0, 1'b0, 3'd0);
        bus.im_hready = 3'b101;
        bus.is_hready = 1'b0;
        bus.is_hresp  = HRESP_ERROR;
        #1;
        checks++;
        if ({bus.om_hresp, bus.om_hready} !== {6'b00_01_00, 3'b101}) begin errors++; $display("FAIL err_first: got hresp=%b hready=%b expected 000100/101", bus.om_hresp, bus.om_hready); end
        tick();
        bus.im_hready = 3'b111;
        bus.is_hready = 1'b1;
        #1;
        checks++;
        if ({bus.om_hresp, bus.om_hready, bus.os_htrans} !== {6'b00_01_00, 3'b111, 2'd0}) begin errors++; $display("FAIL err_second: got hresp=%b hready=%b trans=%0d expected 000100/111/0", bus.om_hresp, bus.om_hready, bus.os_htrans); end
        tick();
        bus.is_hresp = HRESP_OKAY;
    endtask

    task automatic test_fairness();
        do_reset();
        drive(0, HTRANS_NONSEQ, 32'h1000, 1'b0, 3'd0);
        drive(1, HTRANS_NONSEQ, 32'h2000, 1'b0, 3'd0);
        drive(2, HTRANS_NONSEQ, 32'h3000, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_haddr, bus.om_hready} !== {32'h1000, 3'b001}) begin errors++; $display("FAIL rr_g0: got addr=%h hready=%b expected 00001000/001", bus.os_haddr, bus.om_hready); end
        tick();
        bus.im_hready = 3'b001;
        drive(0, HTRANS_NONSEQ, 32'h1004, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_haddr, bus.om_hready} !== {32'h2000, 3'b001}) begin errors++; $display("FAIL rr_g1: got addr=%h hready=%b expected 00002000/001", bus.os_haddr, bus.om_hready); end
        tick();
        bus.im_hready = 3'b010;
        drive(1, HTRANS_NONSEQ, 32'h2004, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_haddr, bus.om_hready} !== {32'h3000, 3'b010}) begin errors++; $display("FAIL rr_g2: got addr=%h hready=%b expected 00003000/010", bus.os_haddr, bus.om_hready); end
        tick();
        bus.im_hready = 3'b100;
        drive(2, HTRANS_NONSEQ, 32'h3004, 1'b0, 3'd0);
        #1;
        checks++;
        if ({bus.os_haddr, bus.om_hready} !== {32'h1004, 3'b100}) begin errors++; $display("FAIL rr_g3: got addr=%h hready=%b expected 00001004/100", bus.os_haddr, bus.om_hready); end
        tick();
        bus.im_hready = 3'b001;
        #1;
        checks++;
        if (bus.om_hready[2] !== 1'b0) begin errors++; $display("FAIL rr_pend2: got hready2=%b expected 0", bus.om_hready[2]); end
        hresetn = 1'b0;
        #1;
        checks++;
        if ({bus.om_hready, bus.os_hsel, bus.os_htrans} !== {3'b111, 1'b0, 2'd0}) begin errors++; $display("FAIL rr_async_rst: got hready=%b sel=%b trans=%0d expected 111/0/0", bus.om_hready, bus.os_hsel, bus.os_htrans); end
        idle_all();
        @(posedge hclk);
        #1 hresetn = 1'b1;
        tick();
        #1;
        checks++;
        if ({bus.om_hready, bus.os_htrans} !== {3'b111, 2'd0}) begin errors++; $display("FAIL rr_pend_cleared: got hready=%b trans=%0d expected 111/0", bus.om_hready, bus.os_htrans); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_burst_lock();
        test_wait();
        test_error();
        test_fairness();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
